// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer that shares one single-port memory
// between an instruction-fetch port (0) and a load/store port (1).
module mem_arbiter #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DIN_W       = 8,
  parameter int unsigned DOUT_W      = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DIN_W-1:0]  wdata0,
  output logic              ack0,
  output logic [DOUT_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DIN_W-1:0]  wdata1,
  output logic              ack1,
  output logic [DOUT_W-1:0] rdata1,
  output logic              MW,
  output logic [ADDR_W-1:0] address,
  output logic [DIN_W-1:0]  DataIn,
  input  logic [DOUT_W-1:0] DataOut,
  output logic              busy,
  output logic [1:0]        gnt
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              last_grant, last_grant_d;
  logic [1:0]        gnt_d;
  logic              busy_d;
  logic              mw_d;
  logic [ADDR_W-1:0] address_d;
  logic [DIN_W-1:0]  data_in_d;
  logic              ack0_d, ack1_d;
  logic [DOUT_W-1:0] rdata0_d, rdata1_d;
  logic              pick1;

  // Port 1 wins when alone, or on contention when port 0 was served last.
  assign pick1 = req1 && (!req0 || !last_grant);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    last_grant_d = last_grant;
    gnt_d        = gnt;
    busy_d       = busy;
    mw_d         = MW;
    address_d    = address;
    data_in_d    = DataIn;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0;
    rdata1_d     = rdata1;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_d      = ACCESS;
          busy_d       = 1'b1;
          cnt_d        = WAIT_LOAD;
          last_grant_d = pick1;
          gnt_d        = pick1 ? 2'b10 : 2'b01;
          mw_d         = pick1 ? we1 : we0;
          address_d    = pick1 ? addr1 : addr0;
          data_in_d    = pick1 ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          state_d = RESP;
          mw_d    = 1'b0;
          if (gnt[1]) begin
            rdata1_d = DataOut;
            ack1_d   = 1'b1;
          end else begin
            rdata0_d = DataOut;
            ack0_d   = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        gnt_d   = 2'b00;
        mw_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the idle values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= 1'b1;
      gnt        <= 2'b00;
      busy       <= 1'b0;
      MW         <= 1'b0;
      address    <= '0;
      DataIn     <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last_grant <= last_grant_d;
      gnt        <= gnt_d;
      busy       <= busy_d;
      MW         <= mw_d;
      address    <= address_d;
      DataIn     <= data_in_d;
      ack0       <= ack0_d;
      ack1       <= ack1_d;
      rdata0     <= rdata0_d;
      rdata1     <= rdata1_d;
    end
  end

endmodule
